// File: rtl/key_expand_seq.sv
// AES key expansion: streams w[0..4*(NK+7)-1] one word per valid/ready transfer, first word one cycle after start.
// Next word is formed combinationally from an NK-word history; word_ready low freezes all state.

module bsbox (
  input  logic [7:0] a,
  output logic [7:0] s
);

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int k = 0; k < 8; k++) begin
      if (y[k]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; zero maps to zero naturally.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] e;
    r = 8'h01;
    e = 8'hfe;
    for (int k = 7; k >= 0; k--) begin
      r = gf_mul(r, r);
      if (e[k]) r = gf_mul(r, x);
    end
    return r;
  endfunction

  logic [7:0] inv;

  always_comb begin
    inv = gf_inv(a);
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

module key_expand_seq #(
  parameter int NK = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         word_valid,
  input  logic         word_ready,
  output logic [31:0]  word_out,
  output logic [5:0]   word_idx,
  output logic         done
);

  localparam int         TOTAL    = 4 * (NK + 7);
  localparam logic [5:0] LAST_IDX = 6'(TOTAL - 1);
  localparam logic [5:0] NK_IDX   = 6'(NK);
  localparam logic [2:0] LAST_POS = 3'(NK - 1);

  generate
    if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
      $error("key_expand_seq: NK must be 4, 6 or 8");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, EMIT, FIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] hist_q [NK];
  logic [5:0]  idx_q;
  logic [2:0]  pos_q;
  logic [7:0]  rcon_q;

  logic        xfer;
  logic        expand_phase;
  logic [31:0] prev_w, sub_in, sub_out, temp, next_w;

  assign xfer         = (state_q == EMIT) && word_ready;
  assign expand_phase = (idx_q >= NK_IDX);
  assign prev_w       = hist_q[NK-1];
  assign sub_in       = (pos_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

  // One S-box lane per byte; the rotation is applied on the input mux only.
  for (genvar b = 0; b < 4; b++) begin : g_sbox
    bsbox u_sbox (.a(sub_in[8*b +: 8]), .s(sub_out[8*b +: 8]));
  end

  // While idx < NK the history still holds raw key words, so w[i] is simply its oldest entry.
  always_comb begin
    temp = prev_w;
    if (pos_q == 3'd0)
      temp = sub_out ^ {rcon_q, 24'h000000};
    else if (NK == 8 && pos_q == 3'd4)
      temp = sub_out;
    next_w = expand_phase ? (hist_q[0] ^ temp) : hist_q[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    busy       = 1'b1;
    word_valid = 1'b0;
    done       = 1'b0;
    word_out   = 32'h0;
    word_idx   = 6'h0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = EMIT;
      end
      EMIT: begin
        word_valid = 1'b1;
        word_out   = next_w;
        word_idx   = idx_q;
        if (word_ready && idx_q == LAST_IDX) state_d = FIN;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < NK; j++) hist_q[j] <= 32'h0;
      idx_q  <= 6'h0;
      pos_q  <= 3'h0;
      rcon_q <= 8'h01;
    end else if (state_q == IDLE && start) begin
      for (int j = 0; j < NK; j++) hist_q[j] <= key_in[255 - 32*j -: 32];
      idx_q  <= 6'h0;
      pos_q  <= 3'h0;
      rcon_q <= 8'h01;
    end else if (xfer) begin
      // Key words rotate through the history unchanged, so after NK transfers it holds w[0..NK-1].
      for (int j = 0; j < NK - 1; j++) hist_q[j] <= hist_q[j+1];
      hist_q[NK-1] <= next_w;
      idx_q <= idx_q + 6'd1;
      pos_q <= (pos_q == LAST_POS) ? 3'd0 : pos_q + 3'd1;
      if (expand_phase && pos_q == 3'd0)
        rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    end
  end

endmodule

// File: doc/key_expand_seq.md
KEY_EXPAND_SEQ -- requirements
Module: key_expand_seq

Interface
REQ-001 The block SHALL have one parameter: NK, default 4, number of 32-bit key words; legal values are 4, 6 and 8 (AES-128/192/256).
REQ-002 The block SHALL treat any other NK value as illegal, and an elaboration-time check SHALL fail on it.
REQ-003 The block SHALL have the following ports, listed as name, direction, width, meaning:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous and active-high.
- start  in  1  request to expand key_in; sampled only in IDLE.
- key_in  in  256  cipher key, MSB-first; word j = key_in[32j:32j+31]; bits from 32*NK upward are ignored.
- busy  out  1  high in every state other than IDLE.
- word_valid  out  1  word_out/word_idx hold a valid word.
- word_ready  in  1  consumer accepts the word; a transfer happens when word_valid and word_ready are both high.
- word_out  out  32  expanded key word w[i], big-endian bit order [0:31].
- word_idx  out  6  index i of word_out.
- done  out  1  one-cycle pulse in the cycle after the last word transfers.

Function
REQ-004 The block SHALL produce TOTAL = 4*(NK+7) words (44/52/60), w[0]..w[TOTAL-1], strictly in index order, one per transfer.
REQ-005 The state machine SHALL have three states: IDLE, EMIT, FIN.
- IDLE->EMIT when start=1: load key words into an NK-deep word history, set i=0, set rcon=0x01.
- EMIT->FIN on transfer of w[TOTAL-1].
- FIN->IDLE unconditionally after one cycle; done=1 only in FIN.
REQ-006 start SHALL be ignored in EMIT and FIN.
REQ-007 In EMIT, word_valid SHALL be 1, and word_out/word_idx SHALL stay stable until a transfer.
REQ-008 w[0] SHALL be presented in the cycle after start is sampled, giving one-cycle latency.
REQ-009 At most one word SHALL transfer per cycle, and a back-to-back transfer SHALL be possible every cycle while word_ready=1.
REQ-010 For i < NK, w[i] SHALL be key word i.
REQ-011 For i >= NK, w[i] = w[i-NK] XOR temp, with temp selected as follows:
- i mod NK = 0: SubWord(RotWord(w[i-1])) XOR {rcon,0x00,0x00,0x00}.
- NK=8 and i mod 8 = 4: SubWord(w[i-1]) with no rotation and no rcon.
- all other i: temp = w[i-1].
REQ-012 RotWord SHALL be a one-byte left rotation, bytes [b0 b1 b2 b3] -> [b1 b2 b3 b0].
REQ-013 SubWord SHALL apply four instances of the team's bSbox S-box, one per byte.
REQ-014 rcon SHALL advance only on transfer of a word with i mod NK = 0 and i >= NK, using xtime(rcon) = (rcon<<1) XOR (0x1B if rcon[7]=1), 8-bit result.
- Sequence: 01,02,04,08,10,20,40,80,1B,36.
REQ-015 The position counter (i mod NK) SHALL wrap from NK-1 to 0 without a divider.
REQ-016 On each transfer, the history SHALL shift so that it always holds w[i-NK..i-1] for the next word.
REQ-017 The next word SHALL be computed combinationally from the history so that the back-to-back rate is sustained with no bubble.
REQ-018 While word_ready=0, neither the history, i nor rcon SHALL change.
REQ-019 The block SHALL keep no inter-key state; each start SHALL restart from key_in alone.

Reset
REQ-020 While rst=1, the block SHALL be in IDLE with busy=0, word_valid=0, done=0, word_out=0, word_idx=0, rcon=0x01 and the history cleared.
REQ-021 An assertion of rst in EMIT or FIN SHALL abort the expansion at once, with no done pulse.
REQ-022 After rst is released, the first start SHALL produce w[0] of the new key_in.

Verification
REQ-023 NK=4, key 2b7e151628aed2a6abf7158809cf4f3c, word_ready=1 -> w[4]=a0fafe17, w[43]=b6630ca6, done pulses once, 45 cycles from start to done.
REQ-024 NK=6, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> w[6]=fe0c91f7, w[51]=01002202, word_idx 0..51 with no gaps.
REQ-025 NK=8, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> w[8]=9ba35411, w[12]=a8b09c1a (SubWord-only path), w[59]=706c631e.
REQ-026 NK=4 with word_ready randomly toggled (about 50%) -> word sequence identical to REQ-023, word_out stable while stalled, and rcon reaches 0x36 at w[40].
REQ-027 rst asserted at word_idx=20, then released and start issued with a new key -> word_valid drops immediately, no done pulse, and the new expansion is correct from w[0].
REQ-028 start held high during EMIT and for the cycle of done -> no restart during EMIT, and a second expansion begins only from IDLE.
